// File: rtl/tl_bus_arbiter_if.sv
// TileLink-UL channel A/D bundle shared by the fetch/LSU requesters and memory.
// One transaction outstanding at a time, so source IDs pass through untouched.
interface tl_bus_arbiter_if;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_size;
    logic [31:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic [3:0]  a_source;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [63:0] d_data;
    logic [3:0]  d_source;

    modport master (
        output a_valid, a_opcode, a_size, a_address,
        output a_mask, a_data, a_source, d_ready,
        input  a_ready, d_valid, d_opcode, d_data, d_source
    );

    modport slave (
        input  a_valid, a_opcode, a_size, a_address,
        input  a_mask, a_data, a_source, d_ready,
        output a_ready, d_valid, d_opcode, d_data, d_source
    );
endinterface

// File: rtl/tl_bus_arbiter.sv
// Two-requester TileLink-UL arbiter: I-cache refill (m0) and D-cache/LSU (m1)
// share one memory port, one A beat and one D beat per grant.
module tl_bus_arbiter #(
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 1024,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    tl_bus_arbiter_if.slave         m0,
    tl_bus_arbiter_if.slave         m1,
    tl_bus_arbiter_if.master        s,
    output logic [1:0]              grant,
    output logic                    busy,
    output logic                    timeout_err
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA
    } state_e;

    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);
    localparam bit               WD_EN  = (TIMEOUT != 0);

    state_e           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             terr_q, terr_d;

    logic       in_addr, in_data;
    logic       req_a_valid, req_d_ready;
    logic       a_hs, d_hs;
    logic [1:0] win;

    assign in_addr     = (state_q == S_ADDR);
    assign in_data     = (state_q == S_DATA);
    assign req_a_valid = sel_q[1] ? m1.a_valid : m0.a_valid;
    assign req_d_ready = sel_q[1] ? m1.d_ready : m0.d_ready;
    assign a_hs        = in_addr && req_a_valid && s.a_ready;
    assign d_hs        = in_data && s.d_valid && req_d_ready;

    // A payload follows the owner; only the valid is gated by state.
    assign s.a_opcode  = sel_q[1] ? m1.a_opcode  : m0.a_opcode;
    assign s.a_size    = sel_q[1] ? m1.a_size    : m0.a_size;
    assign s.a_address = sel_q[1] ? m1.a_address : m0.a_address;
    assign s.a_mask    = sel_q[1] ? m1.a_mask    : m0.a_mask;
    assign s.a_data    = sel_q[1] ? m1.a_data    : m0.a_data;
    assign s.a_source  = sel_q[1] ? m1.a_source  : m0.a_source;
    assign s.a_valid   = in_addr && req_a_valid;
    assign s.d_ready   = in_data && req_d_ready;

    assign m0.a_ready  = in_addr && sel_q[0] && s.a_ready;
    assign m1.a_ready  = in_addr && sel_q[1] && s.a_ready;
    assign m0.d_valid  = in_data && sel_q[0] && s.d_valid;
    assign m1.d_valid  = in_data && sel_q[1] && s.d_valid;
    assign m0.d_opcode = s.d_opcode;
    assign m0.d_data   = s.d_data;
    assign m0.d_source = s.d_source;
    assign m1.d_opcode = s.d_opcode;
    assign m1.d_data   = s.d_data;
    assign m1.d_source = s.d_source;

    // last_q = 1 means m1 was served last, so m0 takes the next tie.
    always_comb begin
        win = 2'b10;
        if (m0.a_valid && m1.a_valid) begin
            win = ((FIXED_PRIO != 0) || last_q) ? 2'b01 : 2'b10;
        end else if (m0.a_valid) begin
            win = 2'b01;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        terr_d  = terr_q;
        unique case (state_q)
            S_IDLE: begin
                if (m0.a_valid || m1.a_valid) begin
                    state_d = S_ADDR;
                    sel_d   = win;
                end
            end
            S_ADDR: begin
                if (a_hs) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
            end
            S_DATA: begin
                if (d_hs) begin
                    state_d = S_IDLE;
                    last_d  = sel_q[1];
                    sel_d   = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                sel_d   = '0;
            end
        endcase
        if (WD_EN && in_data && !d_hs && (cnt_d >= TO_LIM)) begin
            terr_d = 1'b1;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            terr_q  <= terr_d;
        end
    end

    assign grant       = sel_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;
endmodule

// File: tb/tb_tl_bus_arbiter.sv
// Bench for tl_bus_arbiter: round-robin instance (a) and fixed-priority
// instance (b), checked every cycle against a transaction-level model.
module tb_tl_bus_arbiter;
    localparam int TO = 8;
    localparam logic [31:0] ADDR0 = 32'h8000_0008;
    localparam logic [31:0] ADDR1 = 32'h9000_0010;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic a0v[2], a1v[2], sar[2], sdv[2], d0r[2], d1r[2];
    logic [63:0] sdata;

    logic [1:0] grant_a, grant_b;
    logic busy_a, busy_b, terr_a, terr_b;

    tl_bus_arbiter_if ma0 (), ma1 (), sa ();
    tl_bus_arbiter_if mb0 (), mb1 (), sb ();

    assign ma0.a_valid = a0v[0];
    assign ma0.a_opcode = 3'd4;
    assign ma0.a_size = 3'd3;
    assign ma0.a_address = ADDR0;
    assign ma0.a_mask = 8'hff;
    assign ma0.a_data = 64'h0;
    assign ma0.a_source = 4'd0;
    assign ma0.d_ready = d0r[0];
    assign ma1.a_valid = a1v[0];
    assign ma1.a_opcode = 3'd0;
    assign ma1.a_size = 3'd3;
    assign ma1.a_address = ADDR1;
    assign ma1.a_mask = 8'h0f;
    assign ma1.a_data = 64'hdead_beef;
    assign ma1.a_source = 4'd1;
    assign ma1.d_ready = d1r[0];
    assign sa.a_ready = sar[0];
    assign sa.d_valid = sdv[0];
    assign sa.d_opcode = 3'd1;
    assign sa.d_data = sdata;
    assign sa.d_source = 4'd0;

    assign mb0.a_valid = a0v[1];
    assign mb0.a_opcode = 3'd4;
    assign mb0.a_size = 3'd3;
    assign mb0.a_address = ADDR0;
    assign mb0.a_mask = 8'hff;
    assign mb0.a_data = 64'h0;
    assign mb0.a_source = 4'd0;
    assign mb0.d_ready = d0r[1];
    assign mb1.a_valid = a1v[1];
    assign mb1.a_opcode = 3'd0;
    assign mb1.a_size = 3'd3;
    assign mb1.a_address = ADDR1;
    assign mb1.a_mask = 8'h0f;
    assign mb1.a_data = 64'hdead_beef;
    assign mb1.a_source = 4'd1;
    assign mb1.d_ready = d1r[1];
    assign sb.a_ready = sar[1];
    assign sb.d_valid = sdv[1];
    assign sb.d_opcode = 3'd1;
    assign sb.d_data = sdata;
    assign sb.d_source = 4'd0;

    tl_bus_arbiter #(.FIXED_PRIO(0), .TIMEOUT(TO), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .m0(ma0), .m1(ma1), .s(sa),
        .grant(grant_a), .busy(busy_a), .timeout_err(terr_a)
    );

    tl_bus_arbiter #(.FIXED_PRIO(1), .TIMEOUT(TO), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .m0(mb0), .m1(mb1), .s(sb),
        .grant(grant_b), .busy(busy_b), .timeout_err(terr_b)
    );

    // phase: 0 idle, 1 address offered, 2 waiting for D; owner 1=m0, 2=m1
    typedef struct packed {
        int phase;
        int owner;
        int last;
        int wd;
        bit terr;
    } mdl_t;

    localparam mdl_t MRST = '{phase: 0, owner: 0, last: 2, wd: 0, terr: 1'b0};
    mdl_t mdl_a = MRST;
    mdl_t mdl_b = MRST;

    function automatic mdl_t mstep(mdl_t m, int fixed, logic v0, logic v1,
                                   logic ar, logic dv, logic r0, logic r1);
        mdl_t n;
        n = m;
        if (m.phase == 0) begin
            if (v0 || v1) begin
                n.phase = 1;
                if (v0 && v1) n.owner = (fixed != 0 || m.last == 2) ? 1 : 2;
                else n.owner = v0 ? 1 : 2;
            end
        end else if (m.phase == 1) begin
            if ((m.owner == 1 ? v0 : v1) && ar) begin
                n.phase = 2;
                n.wd = 0;
            end
        end else begin
            if (dv && (m.owner == 1 ? r0 : r1)) begin
                n.phase = 0;
                n.last = m.owner;
                n.owner = 0;
            end else begin
                n.wd = (m.wd < 65535) ? m.wd + 1 : m.wd;
                if (n.wd >= TO) n.terr = 1'b1;
            end
        end
        return n;
    endfunction

    // {grant, busy, terr, s.a_valid, m0.a_ready, m1.a_ready,
    //  s.d_ready, m0.d_valid, m1.d_valid}
    function automatic logic [9:0] exp_vec(mdl_t m, logic v0, logic v1,
                                           logic ar, logic dv, logic r0, logic r1);
        logic [1:0] g;
        logic ov, orr;
        g = (m.owner == 1) ? 2'b01 : (m.owner == 2) ? 2'b10 : 2'b00;
        ov = (m.owner == 1) ? v0 : v1;
        orr = (m.owner == 1) ? r0 : r1;
        return {g, m.phase != 0, m.terr,
                m.phase == 1 && ov,
                m.phase == 1 && m.owner == 1 && ar,
                m.phase == 1 && m.owner == 2 && ar,
                m.phase == 2 && orr,
                m.phase == 2 && m.owner == 1 && dv,
                m.phase == 2 && m.owner == 2 && dv};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_a <= MRST;
            mdl_b <= MRST;
        end else begin
            mdl_a <= mstep(mdl_a, 0, a0v[0], a1v[0], sar[0], sdv[0], d0r[0], d1r[0]);
            mdl_b <= mstep(mdl_b, 1, a0v[1], a1v[1], sar[1], sdv[1], d0r[1], d1r[1]);
        end
    end

    logic [1:0] qa[$];
    logic [1:0] qb[$];
    int bad_ar = 0;

    always @(negedge clk) begin
        chk("a_ctl",
            64'({grant_a, busy_a, terr_a, sa.a_valid, ma0.a_ready, ma1.a_ready,
                 sa.d_ready, ma0.d_valid, ma1.d_valid}),
            64'(exp_vec(mdl_a, a0v[0], a1v[0], sar[0], sdv[0], d0r[0], d1r[0])));
        chk("b_ctl",
            64'({grant_b, busy_b, terr_b, sb.a_valid, mb0.a_ready, mb1.a_ready,
                 sb.d_ready, mb0.d_valid, mb1.d_valid}),
            64'(exp_vec(mdl_b, a0v[1], a1v[1], sar[1], sdv[1], d0r[1], d1r[1])));
        if (mdl_a.phase == 1 && sa.a_valid)
            chk("a_addr", 64'(sa.a_address), 64'(mdl_a.owner == 1 ? ADDR0 : ADDR1));
        if (mdl_a.phase == 2 && ma0.d_valid) chk("a_d0", ma0.d_data, sdata);
        if (mdl_a.phase == 2 && ma1.d_valid) chk("a_d1", ma1.d_data, sdata);
        if (sa.a_valid && sa.a_ready) qa.push_back(grant_a);
        if (sb.a_valid && sb.a_ready) qb.push_back(grant_b);
        if (grant_a == 2'b01 && ma1.a_ready) bad_ar++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [1:0] rr_exp[4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    initial begin
        for (int i = 0; i < 2; i++) begin
            a0v[i] = 0; a1v[i] = 0; sar[i] = 0;
            sdv[i] = 0; d0r[i] = 0; d1r[i] = 0;
        end
        sdata = 64'h1122_3344_5566_7788;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 64'(grant_a), 64'h0);
        chk("rst_busy", 64'(busy_a), 64'h0);
        chk("rst_terr", 64'(terr_a), 64'h0);
        chk("rst_avalid", 64'(sa.a_valid), 64'h0);
        rst_n = 1;

        // single requester m0
        a0v[0] = 1; sar[0] = 1;
        tick;
        chk("t1_grant", 64'(grant_a), 64'h1);
        chk("t1_avalid", 64'(sa.a_valid), 64'h1);
        chk("t1_addr", 64'(sa.a_address), 64'h8000_0008);
        tick;
        a0v[0] = 0; sar[0] = 0; sdv[0] = 1; d0r[0] = 1;
        #1;
        chk("t1_dvalid", 64'(ma0.d_valid), 64'h1);
        chk("t1_data", ma0.d_data, 64'h1122_3344_5566_7788);
        tick;
        sdv[0] = 0; d0r[0] = 0;
        chk("t1_idle_grant", 64'(grant_a), 64'h0);
        chk("t1_idle_busy", 64'(busy_a), 64'h0);

        // round-robin tie from reset
        rst_n = 0;
        #1;
        rst_n = 1;
        qa.delete();
        bad_ar = 0;
        a0v[0] = 1; a1v[0] = 1; sar[0] = 1; sdv[0] = 1; d0r[0] = 1; d1r[0] = 1;
        repeat (12) tick;
        a0v[0] = 0; a1v[0] = 0; sar[0] = 0; sdv[0] = 0; d0r[0] = 0; d1r[0] = 0;
        chk("rr_count", 64'(qa.size()), 64'd4);
        for (int i = 0; i < 4 && i < qa.size(); i++)
            chk("rr_grant", 64'(qa[i]), 64'(rr_exp[i]));
        chk("rr_m1_ready", 64'(bad_ar), 64'd0);

        // backpressure on A then on D
        a1v[0] = 1;
        tick;
        for (int i = 0; i < 5; i++) begin
            chk("bp_avalid", 64'(sa.a_valid), 64'h1);
            chk("bp_addr", 64'(sa.a_address), 64'h9000_0010);
            tick;
        end
        sar[0] = 1;
        tick;
        a1v[0] = 0; sar[0] = 0; sdv[0] = 1; d1r[0] = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_dbusy", 64'(busy_a), 64'h1);
            chk("bp_dready", 64'(sa.d_ready), 64'h0);
            tick;
        end
        d1r[0] = 1;
        tick;
        sdv[0] = 0; d1r[0] = 0;
        chk("bp_done", 64'(busy_a), 64'h0);

        // watchdog
        a0v[0] = 1; sar[0] = 1;
        tick;
        tick;
        a0v[0] = 0; sar[0] = 0; d0r[0] = 1;
        repeat (7) tick;
        chk("wd_7", 64'(terr_a), 64'h0);
        tick;
        chk("wd_8", 64'(terr_a), 64'h1);
        sdv[0] = 1;
        tick;
        sdv[0] = 0; d0r[0] = 0;
        chk("wd_idle", 64'(busy_a), 64'h0);
        chk("wd_sticky", 64'(terr_a), 64'h1);
        rst_n = 0;
        #1;
        chk("wd_rst", 64'(terr_a), 64'h0);
        rst_n = 1;

        // asynchronous reset while waiting for D
        a0v[0] = 1; sar[0] = 1;
        tick;
        tick;
        a0v[0] = 0; sar[0] = 0;
        #2;
        chk("ar_busy_pre", 64'(busy_a), 64'h1);
        rst_n = 0;
        #1;
        chk("ar_grant", 64'(grant_a), 64'h0);
        chk("ar_busy", 64'(busy_a), 64'h0);
        #1;
        rst_n = 1;
        a0v[0] = 1; a1v[0] = 1; sar[0] = 1; sdv[0] = 1; d0r[0] = 1; d1r[0] = 1;
        tick;
        chk("ar_tie", 64'(grant_a), 64'h1);
        tick;
        tick;
        a0v[0] = 0; a1v[0] = 0; sar[0] = 0; sdv[0] = 0; d0r[0] = 0; d1r[0] = 0;

        // fixed priority instance
        qb.delete();
        a0v[1] = 1; a1v[1] = 1; sar[1] = 1; sdv[1] = 1; d0r[1] = 1; d1r[1] = 1;
        repeat (12) tick;
        a0v[1] = 0;
        repeat (3) tick;
        a1v[1] = 0; sar[1] = 0; sdv[1] = 0; d0r[1] = 0; d1r[1] = 0;
        chk("fp_count", 64'(qb.size()), 64'd5);
        for (int i = 0; i < 4 && i < qb.size(); i++)
            chk("fp_m0", 64'(qb[i]), 64'h1);
        if (qb.size() >= 5) chk("fp_m1", 64'(qb[4]), 64'h2);

        tick;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
